hamming_rx_deframer: RTL and testbench

Receive-side stage that sits directly upstream of the Hamming decoder data path.
- Accepts a bit-serial channel stream and assembles N = 2**P-1 bit codewords.
- Performs single-error syndrome correction and presents K = 2**P-P-1 corrected data bits on a valid/ready interface.
- Keeps saturating statistics for corrected words and framing slips.

---
 rtl/hamming_pkg.sv | 35 +++
 rtl/hamming_syndrome_corrector.sv | 33 +++
 rtl/hamming_rx_deframer.sv | 113 +++++++++++
 tb/tb_hamming_rx_deframer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared Hamming SEC helpers: code geometry and the data-to-position map.
// The encoder uses the same map.
package hamming_pkg;

  function automatic int n_bits(input int p);
    return (1 << p) - 1;
  endfunction

  function automatic int k_bits(input int p);
    return (1 << p) - p - 1;
  endfunction

  function automatic bit is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Hamming position (1-based) of data bit j; data fills non-power-of-two slots in order
  function automatic int data_pos(input int p, input int j);
    int seen;
    seen     = 0;
    data_pos = 0;
    for (int i = 1; i <= n_bits(p); i++) begin
      if (!is_pow2(i)) begin
        if (seen == j) data_pos = i;
        seen++;
      end
    end
  endfunction

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } rx_state_e;

endpackage

// File: rtl/hamming_syndrome_corrector.sv
// Combinational single-error corrector: syndrome, flip, data extraction.
module hamming_syndrome_corrector
  import hamming_pkg::*;
#(
  parameter  int P = 3,
  localparam int N = n_bits(P),
  localparam int K = k_bits(P)
) (
  input  logic [N-1:0] cw,
  output logic [K-1:0] data,
  output logic         corrected
);

  logic [P-1:0] syn;
  logic [N-1:0] fixed;

  always_comb begin
    syn = '0;
    for (int i = 1; i <= N; i++) begin
      if (cw[i-1]) syn = syn ^ P'(i);
    end
    fixed = cw;
    for (int i = 1; i <= N; i++) begin
      if (syn == P'(i)) fixed[i-1] = ~cw[i-1];
    end
    corrected = (syn != '0);
  end

  for (genvar j = 0; j < K; j++) begin : g_data
    assign data[j] = fixed[data_pos(P, j) - 1];
  end

endmodule

// File: rtl/hamming_rx_deframer.sv
// Serial-to-parallel Hamming deframer: assembles codewords, corrects single
// errors, and presents data on valid/ready with one-word backpressure hold.
module hamming_rx_deframer
  import hamming_pkg::*;
#(
  parameter  int P     = 3,
  parameter  int CNT_W = 16,
  localparam int N     = n_bits(P),
  localparam int K     = k_bits(P)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sop,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [K-1:0]     out_data,
  output logic             out_corrected,
  output logic [CNT_W-1:0] corr_count,
  output logic [CNT_W-1:0] slip_count
);

  rx_state_e        state_q, state_d;
  logic [P-1:0]     cnt_q, cnt_d, pos;
  logic [N-1:0]     cw_q, cw_d, pend_q, pend_d, cw_new, dec_in;
  logic [K-1:0]     out_data_q, out_data_d, dec_data;
  logic             out_valid_q, out_valid_d, out_corr_q, out_corr_d, dec_corr;
  logic [CNT_W-1:0] corr_q, corr_d, slip_q, slip_d;
  logic             accept, last, can_load, load;

  // Single decoder shared between the direct path and the HOLD replay path
  hamming_syndrome_corrector #(.P(P)) u_corr (
    .cw        (dec_in),
    .data      (dec_data),
    .corrected (dec_corr)
  );

  always_comb begin
    accept   = in_valid && (state_q == COLLECT);
    pos      = in_sop ? '0 : cnt_q;
    cw_new   = in_sop ? '0 : cw_q;
    cw_new[pos] = in_bit;
    last     = accept && (pos == P'(N - 1));
    can_load = !out_valid_q || out_ready;
    load     = (last && can_load) || ((state_q == HOLD) && out_ready);
    dec_in   = (state_q == HOLD) ? pend_q : cw_new;

    state_d     = state_q;
    cnt_d       = cnt_q;
    cw_d        = cw_q;
    pend_d      = pend_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_corr_d  = out_corr_q;
    corr_d      = corr_q;
    slip_d      = slip_q;

    if (accept) begin
      cw_d  = cw_new;
      cnt_d = last ? '0 : pos + P'(1);
    end
    if (accept && in_sop && (cnt_q != '0) && (slip_q != '1))
      slip_d = slip_q + CNT_W'(1);

    if (last && !can_load) begin
      pend_d  = cw_new;
      state_d = HOLD;
    end
    if ((state_q == HOLD) && out_ready) state_d = COLLECT;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = dec_data;
      out_corr_d  = dec_corr;
      if (dec_corr && (corr_q != '1)) corr_d = corr_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      cw_q        <= '0;
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_corr_q  <= 1'b0;
      corr_q      <= '0;
      slip_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cw_q        <= cw_d;
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_corr_q  <= out_corr_d;
      corr_q      <= corr_d;
      slip_q      <= slip_d;
    end
  end

  assign in_ready      = (state_q == COLLECT);
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_corrected = out_corr_q;
  assign corr_count    = corr_q;
  assign slip_count    = slip_q;

endmodule

// File: tb/tb_hamming_rx_deframer.sv
// Directed bench for hamming_rx_deframer (P=3, 2-bit counters to reach saturation).
module tb_hamming_rx_deframer;

  localparam int P     = 3;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_sop, in_bit, out_ready;
  logic             in_ready, out_valid, out_corrected;
  logic [3:0]       out_data;
  logic [CNT_W-1:0] corr_count, slip_count;

  int total = 0;
  int bad   = 0;

  // A carries data 4'b1011, B carries data 4'b0110; both are clean codewords
  localparam logic [6:0] WORD_A = 7'b1010101;
  localparam logic [6:0] WORD_B = 7'b0110011;

  always #5 clk = ~clk;

  hamming_rx_deframer #(.P(P), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_sop        (in_sop),
    .in_bit        (in_bit),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_corrected (out_corrected),
    .corr_count    (corr_count),
    .slip_count    (slip_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [6:0] cw);
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_sop   = (i == 0);
      in_bit   = cw[i];
      step();
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_bit   = 1'b0;
  endtask

  initial begin
    logic [6:0] w;
    rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data",  32'(out_data), 0);
    chk("rst_out_corr",  32'(out_corrected), 0);
    chk("rst_in_ready",  32'(in_ready), 1);
    chk("rst_corr_cnt",  32'(corr_count), 0);
    chk("rst_slip_cnt",  32'(slip_count), 0);
    rst = 1'b0;

    // clean word, one-cycle latency
    out_ready = 1'b1;
    send_word(WORD_A);
    chk("clean_valid", 32'(out_valid), 1);
    chk("clean_data",  32'(out_data), 11);
    chk("clean_corr",  32'(out_corrected), 0);
    chk("clean_cnt",   32'(corr_count), 0);
    step();
    chk("clean_drop",  32'(out_valid), 0);

    // position 5 flipped
    send_word(WORD_A ^ 7'b0010000);
    chk("err5_valid", 32'(out_valid), 1);
    chk("err5_data",  32'(out_data), 11);
    chk("err5_corr",  32'(out_corrected), 1);
    chk("err5_cnt",   32'(corr_count), 1);
    step();
    chk("err5_drop",  32'(out_valid), 0);

    // backpressure: A on output, B into HOLD, third word refused
    out_ready = 1'b0;
    send_word(WORD_A);
    chk("bp_w1_valid", 32'(out_valid), 1);
    chk("bp_w1_data",  32'(out_data), 11);
    send_word(WORD_B);
    chk("bp_hold_rdy", 32'(in_ready), 0);
    chk("bp_w1_keep",  32'(out_data), 11);
    in_valid = 1'b1; in_sop = 1'b1; in_bit = 1'b1;
    step();
    chk("bp_w3_rdy",   32'(in_ready), 0);
    step();
    chk("bp_w1_stab",  32'(out_data), 11);
    chk("bp_w1_vstab", 32'(out_valid), 1);
    in_valid = 1'b0; in_sop = 1'b0; in_bit = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_w2_valid", 32'(out_valid), 1);
    chk("bp_w2_data",  32'(out_data), 6);
    chk("bp_w2_corr",  32'(out_corrected), 0);
    chk("bp_ret_rdy",  32'(in_ready), 1);
    step();
    chk("bp_w2_drop",  32'(out_valid), 0);
    chk("bp_slip",     32'(slip_count), 0);

    // 4-bit partial word, then sop restarts with a clean word
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_sop = (i == 0); in_bit = 1'b1;
      step();
    end
    in_valid = 1'b0; in_sop = 1'b0; in_bit = 1'b0;
    chk("slip_pre",    32'(slip_count), 0);
    chk("slip_noout",  32'(out_valid), 0);
    send_word(WORD_B);
    chk("slip_cnt",    32'(slip_count), 1);
    chk("slip_valid",  32'(out_valid), 1);
    chk("slip_data",   32'(out_data), 6);
    chk("slip_corr",   32'(out_corrected), 0);
    step();

    // reset while holding
    out_ready = 1'b0;
    send_word(WORD_A);
    send_word(WORD_B);
    chk("rh_hold_rdy", 32'(in_ready), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rh_valid",    32'(out_valid), 0);
    chk("rh_in_ready", 32'(in_ready), 1);
    chk("rh_corr_cnt", 32'(corr_count), 0);
    chk("rh_slip_cnt", 32'(slip_count), 0);
    chk("rh_data",     32'(out_data), 0);
    out_ready = 1'b1;
    send_word(WORD_A);
    chk("rh_post_vld", 32'(out_valid), 1);
    chk("rh_post_dat", 32'(out_data), 11);
    step();

    // five single-error words; 2-bit counter saturates at 3
    for (int k = 0; k < 5; k++) begin
      w = WORD_A ^ (7'd1 << k);
      send_word(w);
      chk("sat_data", 32'(out_data), 11);
      chk("sat_corr", 32'(out_corrected), 1);
      chk("sat_cnt",  32'(corr_count), (k + 1 > 3) ? 3 : k + 1);
    end
    step();
    chk("sat_final", 32'(corr_count), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
